// File: rtl/pl_sysref_gen.sv
// PL-sourced SYSREF pulse generator: burst or continuous pulse trains with a
// configurable period and high time, all logic on pl_clk.
module pl_sysref_gen #(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                pl_clk,
  input  logic                pl_resetn,
  input  logic                enable,
  input  logic                start,
  input  logic                stop,
  input  logic                mode_cont,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] high_cycles,
  input  logic [CNT_W-1:0]    pulse_count,
  output logic                sysref_out,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic [CNT_W-1:0]    pulses_sent
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t              state, state_nx;
  logic [PERIOD_W-1:0] ph, ph_nx;
  logic [PERIOD_W-1:0] per_q, per_nx, hi_q, hi_nx;
  logic [CNT_W-1:0]    cnt_q, cnt_nx, sent_nx;
  logic                cont_q, cont_nx;
  logic                pend, pend_nx;
  logic                done_nx, err_nx;
  logic                cfg_ok, high_end, low_end, burst_end;

  assign cfg_ok = (period >= PERIOD_W'(2)) && (high_cycles != '0) &&
                  (high_cycles < period) && (mode_cont || (pulse_count != '0));
  assign high_end  = (ph == hi_q - PERIOD_W'(1));
  assign low_end   = (ph == per_q - PERIOD_W'(1));
  assign burst_end = !cont_q && (pulses_sent == cnt_q);

  // Next-state, phase counter and pulse bookkeeping
  always_comb begin
    state_nx = state;
    ph_nx    = ph;
    per_nx   = per_q;
    hi_nx    = hi_q;
    cnt_nx   = cnt_q;
    cont_nx  = cont_q;
    sent_nx  = pulses_sent;
    pend_nx  = pend;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      pend_nx  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              per_nx   = period;
              hi_nx    = high_cycles;
              cnt_nx   = pulse_count;
              cont_nx  = mode_cont;
              ph_nx    = '0;
              sent_nx  = CNT_W'(1);
              pend_nx  = 1'b0;
              state_nx = HIGH;
            end else begin
              err_nx = 1'b1;
            end
          end
        end
        HIGH: begin
          if (stop) pend_nx = 1'b1;
          ph_nx = ph + PERIOD_W'(1);
          if (high_end) state_nx = LOW;
        end
        LOW: begin
          if (stop) pend_nx = 1'b1;
          if (low_end) begin
            ph_nx = '0;
            // A stop arriving on the final gap cycle still ends cleanly here
            if (burst_end || pend || stop) begin
              state_nx = IDLE;
              done_nx  = 1'b1;
              pend_nx  = 1'b0;
            end else begin
              state_nx = HIGH;
              if (pulses_sent != '1) sent_nx = pulses_sent + CNT_W'(1);
            end
          end else begin
            ph_nx = ph + PERIOD_W'(1);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge pl_clk or negedge pl_resetn) begin
    if (!pl_resetn) begin
      state       <= IDLE;
      ph          <= '0;
      per_q       <= '0;
      hi_q        <= '0;
      cnt_q       <= '0;
      cont_q      <= 1'b0;
      pend        <= 1'b0;
      pulses_sent <= '0;
      sysref_out  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_nx;
      ph          <= ph_nx;
      per_q       <= per_nx;
      hi_q        <= hi_nx;
      cnt_q       <= cnt_nx;
      cont_q      <= cont_nx;
      pend        <= pend_nx;
      pulses_sent <= sent_nx;
      sysref_out  <= (state_nx == HIGH);
      busy        <= (state_nx != IDLE);
      done        <= done_nx;
      cfg_err     <= err_nx;
    end
  end

endmodule

// File: tb/tb_pl_sysref_gen.sv
// Directed bench for pl_sysref_gen: burst, continuous, bad config, abort,
// start-while-busy and async reset, with hand-derived cycle expectations.
module tb_pl_sysref_gen;

  logic        pl_clk = 1'b0;
  logic        pl_resetn;
  logic        enable, start, stop, mode_cont;
  logic [15:0] period, high_cycles;
  logic [7:0]  pulse_count;
  logic        sysref_out, busy, done, cfg_err;
  logic [7:0]  pulses_sent;

  int n_checks = 0;
  int n_errors = 0;

  pl_sysref_gen #(.PERIOD_W(16), .CNT_W(8)) dut (
    .pl_clk      (pl_clk),
    .pl_resetn   (pl_resetn),
    .enable      (enable),
    .start       (start),
    .stop        (stop),
    .mode_cont   (mode_cont),
    .period      (period),
    .high_cycles (high_cycles),
    .pulse_count (pulse_count),
    .sysref_out  (sysref_out),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .pulses_sent (pulses_sent)
  );

  always #5 pl_clk = ~pl_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pl_clk);
    #1;
  endtask

  // Presents a 1-cycle start; returns sampling cycle c1
  task automatic do_start(input logic cont, input logic [15:0] per, input logic [15:0] hi,
                          input logic [7:0] cnt);
    mode_cont   = cont;
    period      = per;
    high_cycles = hi;
    pulse_count = cnt;
    start       = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic chk_cyc(input string t, input int k, input logic es, input logic ed,
                         input logic eb);
    check($sformatf("%s_sysref_c%0d", t, k), 32'(sysref_out), 32'(es));
    check($sformatf("%s_done_c%0d", t, k), 32'(done), 32'(ed));
    check($sformatf("%s_busy_c%0d", t, k), 32'(busy), 32'(eb));
  endtask

  initial begin
    int done_cnt;
    pl_resetn = 1'b0;
    enable = 1'b1; start = 1'b0; stop = 1'b0; mode_cont = 1'b0;
    period = '0; high_cycles = '0; pulse_count = '0;
    #3;
    check("rst_sysref", 32'(sysref_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    check("rst_sent", 32'(pulses_sent), 0);
    #10 pl_resetn = 1'b1;
    tick();

    // 1: burst of 4, period 10, high 3
    do_start(1'b0, 16'd10, 16'd3, 8'd4);
    for (int k = 1; k <= 42; k++) begin
      chk_cyc("burst", k, (k <= 40) && (((k - 1) % 10) < 3), k == 41, k <= 40);
      if (k == 1) check("burst_sent_c1", 32'(pulses_sent), 1);
      if (k < 42) tick();
    end
    check("burst_sent_end", 32'(pulses_sent), 4);

    // 2: continuous, period 8, high 2, stop during 2nd HIGH
    do_start(1'b1, 16'd8, 16'd2, 8'd0);
    done_cnt = 0;
    for (int k = 1; k <= 18; k++) begin
      chk_cyc("cont", k, (k <= 2) || (k == 9) || (k == 10), k == 17, k <= 16);
      if (done) done_cnt++;
      if (k == 9) stop = 1'b1;
      tick();
      stop = 1'b0;
    end
    check("cont_done_once", 32'(done_cnt), 1);
    check("cont_sent", 32'(pulses_sent), 2);

    // 3: bad configs
    do_start(1'b0, 16'd5, 16'd5, 8'd1);
    check("bad_hi_eq_per_err", 32'(cfg_err), 1);
    check("bad_hi_eq_per_busy", 32'(busy), 0);
    check("bad_hi_eq_per_sysref", 32'(sysref_out), 0);
    tick();
    check("bad_err_one_cycle", 32'(cfg_err), 0);
    check("bad_sent_held", 32'(pulses_sent), 2);
    do_start(1'b0, 16'd1, 16'd1, 8'd1);
    check("bad_per1_err", 32'(cfg_err), 1);
    check("bad_per1_busy", 32'(busy), 0);
    tick();
    do_start(1'b0, 16'd10, 16'd3, 8'd0);
    check("bad_cnt0_err", 32'(cfg_err), 1);
    check("bad_cnt0_sysref", 32'(sysref_out), 0);
    tick();
    enable = 1'b0;
    do_start(1'b0, 16'd5, 16'd5, 8'd1);
    enable = 1'b1;
    check("dis_start_no_err", 32'(cfg_err), 0);
    check("dis_start_idle", 32'(busy), 0);

    // 4: abort in 3rd HIGH of a burst of 10
    do_start(1'b0, 16'd10, 16'd3, 8'd10);
    for (int k = 1; k <= 22; k++) begin
      chk_cyc("abort", k, ((k - 1) % 10) < 3, 1'b0, 1'b1);
      if (k < 22) tick();
    end
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check("abort_sysref", 32'(sysref_out), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_no_done", 32'(done), 0);
    check("abort_sent", 32'(pulses_sent), 3);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("abort_idle_sysref_%0d", k), 32'(sysref_out), 0);
      check($sformatf("abort_idle_done_%0d", k), 32'(done), 0);
      tick();
    end
    do_start(1'b0, 16'd4, 16'd1, 8'd2);
    check("restart_sent", 32'(pulses_sent), 1);
    for (int k = 1; k <= 9; k++) begin
      chk_cyc("restart", k, (k == 1) || (k == 5), k == 9, k <= 8);
      if (k < 9) tick();
    end
    check("restart_sent_end", 32'(pulses_sent), 2);
    tick();

    // 5: start while busy with different config is ignored
    do_start(1'b1, 16'd6, 16'd2, 8'd0);
    for (int k = 1; k <= 19; k++) begin
      chk_cyc("busy_start", k, (k <= 18) && (((k - 1) % 6) < 2), k == 19, k <= 18);
      if (k == 3) begin
        start = 1'b1; period = 16'd20; high_cycles = 16'd10; mode_cont = 1'b0;
      end
      if (k == 14) stop = 1'b1;
      if (k < 19) tick();
      start = 1'b0;
      stop  = 1'b0;
    end
    check("busy_start_sent", 32'(pulses_sent), 3);
    tick();

    // start and stop together in IDLE: burst runs to full count
    stop = 1'b1;
    do_start(1'b0, 16'd4, 16'd2, 8'd3);
    for (int k = 1; k <= 13; k++) begin
      chk_cyc("ss", k, (k <= 12) && (((k - 1) % 4) < 2), k == 13, k <= 12);
      if (k < 13) tick();
    end
    check("ss_sent", 32'(pulses_sent), 3);
    tick();

    // 6: async reset mid-HIGH, then period 2 high 1 toggle
    do_start(1'b1, 16'd10, 16'd5, 8'd0);
    tick();
    check("pre_rst_sysref", 32'(sysref_out), 1);
    #1 pl_resetn = 1'b0;
    #1;
    check("arst_sysref", 32'(sysref_out), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_sent", 32'(pulses_sent), 0);
    check("arst_done", 32'(done), 0);
    #1 pl_resetn = 1'b1;
    tick();
    check("post_rst_idle", 32'(busy), 0);
    do_start(1'b0, 16'd2, 16'd1, 8'd3);
    for (int k = 1; k <= 8; k++) begin
      chk_cyc("toggle", k, (k <= 5) && ((k % 2) == 1), k == 7, k <= 6);
      if (k < 8) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
